// File: rtl/prog_loader.sv
// Boot-time program loader: streams a length-prefixed byte image from a host into instruction memory.
// Optional feature macro: LOADER_CHECKSUM_EN adds a trailing XOR checksum byte and a sticky error state.
module prog_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [7:0]        imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_DATA  = 3'd2,
`ifdef LOADER_CHECKSUM_EN
    S_CHECK = 3'd3,
`endif
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic              in_ready_q, in_ready_d;
  logic              imem_we_q, imem_we_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [7:0]        imem_wdata_q, imem_wdata_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              done_q, done_d;
  logic              accept_s;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
  logic              error_q, error_d;
`endif

  // A length byte of zero encodes a full 2^ADDR_W image, so the last index is all ones.
  function automatic logic [ADDR_W-1:0] len_to_last(input logic [7:0] len);
    if (len == 8'd0) begin
      return {ADDR_W{1'b1}};
    end else begin
      return ADDR_W'(len) - ADDR_ONE;
    end
  endfunction

  function automatic logic takes_input(input state_t s);
    case (s)
      S_LEN:   return 1'b1;
      S_DATA:  return 1'b1;
`ifdef LOADER_CHECKSUM_EN
      S_CHECK: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

`ifdef LOADER_CHECKSUM_EN
  function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction
`endif

  assign accept_s = in_valid & in_ready_q;

  // Next-state and datapath decode; outputs are derived from the next state so they register in step with it.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    last_d       = last_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
`ifdef LOADER_CHECKSUM_EN
    csum_d       = csum_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LEN;
          ptr_d   = {ADDR_W{1'b0}};
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LEN: begin
        if (accept_s) begin
          last_d  = len_to_last(in_data);
          state_d = S_DATA;
`ifdef LOADER_CHECKSUM_EN
          csum_d  = in_data;
`endif
        end else begin
          state_d = S_LEN;
        end
      end
      S_DATA: begin
        if (accept_s) begin
          imem_we_d    = 1'b1;
          imem_addr_d  = ptr_q;
          imem_wdata_d = in_data;
          ptr_d        = ptr_q + ADDR_ONE;
`ifdef LOADER_CHECKSUM_EN
          csum_d       = csum_step(csum_q, in_data);
`endif
          if (ptr_q == last_q) begin
`ifdef LOADER_CHECKSUM_EN
            state_d = S_CHECK;
`else
            state_d = S_DONE;
`endif
          end else begin
            state_d = S_DATA;
          end
        end else begin
          state_d = S_DATA;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (accept_s) begin
          if (in_data == csum_q) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ERR;
          end
        end else begin
          state_d = S_CHECK;
        end
      end
`endif
      S_DONE: begin
        state_d = S_IDLE;
      end
      S_ERR: begin
        if (start) begin
          state_d = S_LEN;
          ptr_d   = {ADDR_W{1'b0}};
        end else begin
          state_d = S_ERR;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    in_ready_d = takes_input(state_d);
    // done trails the DONE state by a cycle so it lands after the final memory write; hold covers it.
    done_d     = (state_q == S_DONE);
    cpu_hold_d = (state_d != S_IDLE) || (state_q == S_DONE);
`ifdef LOADER_CHECKSUM_EN
    error_d    = (state_d == S_ERR);
`endif
  end

  // State and registered outputs with synchronous reset taking priority over everything.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      ptr_q        <= {ADDR_W{1'b0}};
      last_q       <= {ADDR_W{1'b0}};
      in_ready_q   <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= {ADDR_W{1'b0}};
      imem_wdata_q <= 8'd0;
      cpu_hold_q   <= 1'b0;
      done_q       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_q       <= 8'd0;
      error_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      last_q       <= last_d;
      in_ready_q   <= in_ready_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      cpu_hold_q   <= cpu_hold_d;
      done_q       <= done_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q       <= csum_d;
      error_q      <= error_d;
`endif
    end
  end

  assign in_ready   = in_ready_q;
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign cpu_hold   = cpu_hold_q;
  assign done       = done_q;
`ifdef LOADER_CHECKSUM_EN
  assign error      = error_q;
`else
  assign error      = 1'b0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: drivers queue expected memory writes, a negedge monitor checks them.
module tb_prog_loader;
  localparam int ADDR_W = 8;

  logic              clock = 1'b0;
  logic              reset;
  logic              start;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [7:0]        imem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              error;

  int total  = 0;
  int bad    = 0;
  int writes = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_e;

  prog_loader #(.ADDR_W(ADDR_W)) dut (
    .clock(clock), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_hold(cpu_hold), .done(done), .error(error)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, got, want);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clock) begin
    if (imem_we === 1'b1) begin
      writes++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got addr=%0h data=%0h want no write", imem_addr, imem_wdata);
      end else begin
        exp_e = exp_q.pop_front();
        chk("write_addr", int'(imem_addr), int'(exp_e[15:8]));
        chk("write_data", int'(imem_wdata), int'(exp_e[7:0]));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [7:0] b);
    bit got = 1'b0;
    in_valid = 1'b1;
    in_data  = b;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clock);
      if (in_ready === 1'b1) got = 1'b1;
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got in_ready=0 want 1 for byte %0h", b);
      in_valid = 1'b0;
    end else begin
      @(posedge clock);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic send_data(input logic [7:0] b, input logic [7:0] addr);
    exp_q.push_back({addr, b});
    send(b);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_in_ready"}, int'(in_ready), 0);
    chk({tag, "_imem_we"}, int'(imem_we), 0);
    chk({tag, "_imem_addr"}, int'(imem_addr), 0);
    chk({tag, "_imem_wdata"}, int'(imem_wdata), 0);
    chk({tag, "_cpu_hold"}, int'(cpu_hold), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_error"}, int'(error), 0);
  endtask

  // Called right after the last data handshake; cs is only sent when the checksum stage exists.
  task automatic end_session(input logic [7:0] cs);
`ifdef LOADER_CHECKSUM_EN
    send(cs);
`else
    chk("last_write_we", int'(imem_we), 1);
`endif
    chk("done_early", int'(done), 0);
    @(posedge clock);
    #1;
    chk("done_pulse", int'(done), 1);
    chk("done_hold", int'(cpu_hold), 1);
    chk("done_not_ready", int'(in_ready), 0);
    chk("done_error", int'(error), 0);
    @(posedge clock);
    #1;
    chk("done_one_cycle", int'(done), 0);
    chk("hold_release", int'(cpu_hold), 0);
  endtask

  int w0;

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    chk_all_zero("reset");

    // Basic 3-byte image at full rate
    pulse_start();
    chk("len_hold", int'(cpu_hold), 1);
    chk("len_ready", int'(in_ready), 1);
    send(8'h03);
    send_data(8'h11, 8'h00);
    send_data(8'h22, 8'h01);
    send_data(8'h33, 8'h02);
    end_session(8'h03);

    // in_valid toggling between bytes
    pulse_start();
    send(8'h04);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        @(posedge clock);
        #1;
      end
      send_data(8'h40 + 8'(i), 8'(i));
    end
    end_session(8'h04);

    // start during DATA must be ignored
    pulse_start();
    send(8'h03);
    send_data(8'hAA, 8'h00);
    start = 1'b1;
    send_data(8'hBB, 8'h01);
    start = 1'b0;
    send_data(8'hCC, 8'h02);
    end_session(8'hDE);

    // Full 256-byte image
    w0 = writes;
    pulse_start();
    send(8'h00);
    for (int i = 0; i < 256; i++) begin
      send_data(8'(i), 8'(i));
    end
    end_session(8'h00);
    chk("full_write_count", writes - w0, 256);

    // Mid-session reset, then a fresh load
    pulse_start();
    send(8'h04);
    send_data(8'hD1, 8'h00);
    send_data(8'hD2, 8'h01);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    chk_all_zero("midrst");
    pulse_start();
    send(8'h01);
    send_data(8'h77, 8'h00);
    end_session(8'h76);

`ifdef LOADER_CHECKSUM_EN
    pulse_start();
    send(8'h02);
    send_data(8'hA5, 8'h00);
    send_data(8'h5A, 8'h01);
    end_session(8'hFD);

    pulse_start();
    send(8'h02);
    send_data(8'hA5, 8'h00);
    send_data(8'h5A, 8'h01);
    send(8'h00);
    chk("err_flag", int'(error), 1);
    chk("err_hold", int'(cpu_hold), 1);
    chk("err_not_ready", int'(in_ready), 0);
    chk("err_no_done", int'(done), 0);
    in_valid = 1'b1;
    in_data  = 8'h99;
    repeat (5) @(posedge clock);
    #1;
    in_valid = 1'b0;
    chk("err_sticky", int'(error), 1);
    chk("err_sticky_hold", int'(cpu_hold), 1);
    pulse_start();
    chk("err_cleared", int'(error), 0);
    chk("err_restart_ready", int'(in_ready), 1);
    chk("err_restart_hold", int'(cpu_hold), 1);
    send(8'h01);
    send_data(8'h12, 8'h00);
    end_session(8'h13);
`endif

    repeat (3) @(posedge clock);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, meaning the instruction-memory address width; maximum program length is 2^ADDR_W bytes.
REQ-002 The block SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, a synchronous active-high reset.
REQ-004 The block SHALL have port start, input, 1, a one-cycle request to begin a load session.
REQ-005 The block SHALL have port in_valid, input, 1, meaning the host byte is valid.
REQ-006 The block SHALL have port in_data, input, 8, the host byte.
REQ-007 The block SHALL have port in_ready, output, 1, meaning the loader accepts a byte this cycle; a byte transfers when in_valid and in_ready are both 1.
REQ-008 The block SHALL have port imem_we, output, 1, the instruction-memory write strobe.
REQ-009 The block SHALL have port imem_addr, output, ADDR_W, the instruction-memory write address.
REQ-010 The block SHALL have port imem_wdata, output, 8, the instruction byte (opcode[7:4], fields[3:0]).
REQ-011 The block SHALL have port cpu_hold, output, 1, which keeps the processor in reset while 1.
REQ-012 The block SHALL have port done, output, 1, a one-cycle pulse on successful load.
REQ-013 The block SHALL have port error, output, 1, a sticky load-failure flag.

Function
REQ-014 The FSM SHALL have states IDLE, LEN, DATA, CHECK, DONE and ERR.
REQ-015 In IDLE, in_ready=0 and cpu_hold=0; start=1 SHALL move to LEN with cpu_hold=1 from the next cycle.
REQ-016 In LEN, in_ready=1; an accepted byte L SHALL set the count to L, with L=0 meaning 2^ADDR_W, and SHALL move to DATA.
REQ-017 In DATA, in_ready=1, one byte per cycle; the k-th accepted byte (k from 0) SHALL produce imem_we=1, imem_addr=k, imem_wdata=byte, registered and asserted exactly one cycle after the handshake.
REQ-018 imem_we SHALL be 0 in every cycle that does not follow an accepted DATA byte; in_valid=0 stalls the session indefinitely with no timeout.
REQ-019 After the count-th DATA byte, the FSM SHALL go to CHECK when LOADER_CHECKSUM_EN is defined, otherwise to DONE.
REQ-020 The address counter SHALL be exactly ADDR_W wide; writing 2^ADDR_W bytes ends at address 2^ADDR_W-1 with no wrap write.
REQ-021 In CHECK, in_ready=1; the accepted byte SHALL be compared with the running XOR of L and all DATA bytes; equal goes to DONE, unequal goes to ERR.
REQ-022 DONE SHALL last one cycle with done=1 and cpu_hold=1, then go to IDLE, where cpu_hold=0.
REQ-023 In ERR, error=1, cpu_hold=1 and in_ready=0; only start or reset SHALL leave ERR, and start clears error and enters LEN.
REQ-024 start SHALL be ignored in LEN, DATA, CHECK and DONE.
REQ-025 Bytes presented while in_ready=0 SHALL not be consumed.

Reset
REQ-026 reset SHALL override every other input in the same cycle, including mid-session.
REQ-027 On reset the FSM SHALL enter IDLE with in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_hold=0, done=0, error=0, and count and checksum cleared.
REQ-028 After a mid-session reset, already-written memory locations SHALL remain as written; no rollback occurs.

Configuration
REQ-029 With macro LOADER_CHECKSUM_EN defined, the CHECK state and XOR accumulator SHALL be compiled in and behave per REQ-021.
REQ-030 Without LOADER_CHECKSUM_EN, the CHECK state and accumulator SHALL be absent, error SHALL be tied to 0, and the session SHALL be LEN then DATA then DONE.

Verification
REQ-031 The bench SHALL check: start; bytes 03, 11, 22, 33 at full rate, no checksum -> imem_we pulses at addr 0,1,2 with data 11,22,33; done pulse one cycle after the last write; cpu_hold falls the cycle after done.
REQ-032 The bench SHALL check, with LOADER_CHECKSUM_EN: 02, A5, 5A, checksum FD -> done=1, error=0; the same with checksum 00 -> error=1 sticky, cpu_hold=1, in_ready=0.
REQ-033 The bench SHALL check: length 00, then 256 bytes of value i -> last write at addr FF with data FF, exactly 256 imem_we pulses.
REQ-034 The bench SHALL check: in_valid toggled 1/0 every cycle during DATA -> writes occur only after valid handshakes, with addresses contiguous.
REQ-035 The bench SHALL check: reset asserted after the 2nd of 4 DATA bytes -> next cycle IDLE with all outputs 0; a fresh start with 01, 77 writes 77 at addr 0.
REQ-036 The bench SHALL check: start pulsed in DATA -> ignored; start in ERR -> error clears and the loader enters LEN.
